reg_coef_solve: RTL and testbench

- Regression-coefficient stage of the option-pricing (least-squares) datapath.
- Consumes the symmetric 2x2 inverse [[a,b],[b,c]] from the matrix-inverse stage and the vector [sum_y, sum_xy] from the X^T*Y accumulator.
- Computes beta0 = a*sum_y + b*sum_xy and beta1 = b*sum_y + c*sum_xy with one shared multiplier over 4 cycles.
- Delivers both coefficients to the continuation-value stage over a valid/ready handshake.

---
 rtl/reg_coef_solve_pkg.sv | 30 +++
 rtl/reg_coef_sat32.sv | 21 ++
 rtl/reg_coef_solve.sv | 194 +++++++++++++++++++
 tb/tb_reg_coef_solve.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_coef_solve_pkg.sv
// Shared definitions for the regression-coefficient stage: fixed-point
// formats of the inverse elements, default operand/result formats,
// accumulator widths and the controller state encoding.
package reg_coef_solve_pkg;

  localparam int A_FRAC       = 10;
  localparam int B_FRAC       = 8;
  localparam int C_FRAC       = 6;

  localparam int FRAC_Y_DEF   = 8;
  localparam int FRAC_XY_DEF  = 12;
  localparam int OUT_FRAC_DEF = 16;

  localparam int PROD_W       = 66;
  localparam int ACC_W        = 72;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MUL     = 2'd1,
    SAT     = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Half-LSB bias for a right shift of sh bits; nothing to add when sh is 0.
  function automatic logic signed [ACC_W-1:0] round_bias(input int sh);
    round_bias = '0;
    if (sh > 0) round_bias = ACC_W'(1) << (sh - 1);
  endfunction

endpackage

// File: rtl/reg_coef_sat32.sv
// Combinational clamp of a 72-bit signed accumulator into a 32-bit signed
// coefficient, flagging when the value did not fit.
module reg_coef_sat32
  import reg_coef_solve_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [31:0]      value,
  output logic                    ovf
);

  // The value fits when every bit above bit 30 matches the sign bit.
  always_comb begin
    value = acc[31:0];
    ovf   = 1'b0;
    if (acc[ACC_W-1:31] != {(ACC_W-31){acc[ACC_W-1]}}) begin
      ovf   = 1'b1;
      value = acc[ACC_W-1] ? 32'sh80000000 : 32'sh7FFFFFFF;
    end
  end

endmodule

// File: rtl/reg_coef_solve.sv
// Regression-coefficient stage: beta0 = a*sum_y + b*sum_xy and
// beta1 = b*sum_y + c*sum_xy from one shared multiplier over four cycles,
// then saturation to 32 bits and a valid/ready hand-off downstream.
// Optional build macro REG_COEF_ROUND_EN: round half up when aligning each
// product instead of truncating toward -inf.
module reg_coef_solve
  import reg_coef_solve_pkg::*;
#(
  parameter int FRAC_Y   = FRAC_Y_DEF,
  parameter int FRAC_XY  = FRAC_XY_DEF,
  parameter int OUT_FRAC = OUT_FRAC_DEF
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inv_valid,
  input  logic signed [31:0] inv_a,
  input  logic signed [19:0] inv_b,
  input  logic signed [20:0] inv_c,
  input  logic               xty_valid,
  input  logic [32:0]        sum_y,
  input  logic [32:0]        sum_xy,
  output logic               coef_valid,
  input  logic               coef_ready,
  output logic signed [31:0] beta0,
  output logic signed [31:0] beta1,
  output logic               sat,
  output logic               busy
);

  // Alignment shifts bring each product's fraction down to OUT_FRAC bits.
  localparam int SH0 = A_FRAC + FRAC_Y  - OUT_FRAC;
  localparam int SH1 = B_FRAC + FRAC_XY - OUT_FRAC;
  localparam int SH2 = B_FRAC + FRAC_Y  - OUT_FRAC;
  localparam int SH3 = C_FRAC + FRAC_XY - OUT_FRAC;

`ifdef REG_COEF_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND0 = round_bias(SH0);
  localparam logic signed [ACC_W-1:0] RND1 = round_bias(SH1);
  localparam logic signed [ACC_W-1:0] RND2 = round_bias(SH2);
  localparam logic signed [ACC_W-1:0] RND3 = round_bias(SH3);
`else
  localparam logic signed [ACC_W-1:0] RND0 = '0;
  localparam logic signed [ACC_W-1:0] RND1 = '0;
  localparam logic signed [ACC_W-1:0] RND2 = '0;
  localparam logic signed [ACC_W-1:0] RND3 = '0;
`endif

  state_t                   state, next_state;
  logic [1:0]               k;
  logic                     inv_prev, inv_got, xty_got;
  logic signed [31:0]       a_r;
  logic signed [19:0]       b_r;
  logic signed [20:0]       c_r;
  logic [32:0]              sy_r, sxy_r;
  logic signed [ACC_W-1:0]  acc0, acc1;
  logic                     inv_rise, capture_en, mul_en, load_en, accept;
  logic signed [31:0]       mul_coef;
  logic signed [33:0]       mul_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, aligned;
  logic signed [31:0]       sat0_val, sat1_val;
  logic                     ovf0, ovf1;

  assign inv_rise = inv_valid & ~inv_prev;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= next_state;
  end

  // Next-state logic; the COLLECT check looks at the registered got-flags.
  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (inv_got && xty_got) next_state = MUL;
      MUL:     if (k == 2'd3)          next_state = SAT;
      SAT:                             next_state = DONE;
      DONE:    if (coef_ready)         next_state = COLLECT;
      default:                         next_state = COLLECT;
    endcase
  end

  // Per-state control strobes and the busy indication.
  always_comb begin
    capture_en = (state == COLLECT);
    mul_en     = (state == MUL);
    load_en    = (state == SAT);
    accept     = (state == DONE) && coef_valid && coef_ready;
    busy       = (state != COLLECT);
  end

  // Operand capture; the inv_valid history tracks every cycle so a level
  // held high across a solve cannot re-trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_prev <= 1'b1;
      inv_got  <= 1'b0;
      xty_got  <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      sy_r     <= '0;
      sxy_r    <= '0;
    end else begin
      inv_prev <= inv_valid;
      if (capture_en && inv_rise) begin
        a_r     <= inv_a;
        b_r     <= inv_b;
        c_r     <= inv_c;
        inv_got <= 1'b1;
      end
      if (capture_en && xty_valid) begin
        sy_r    <= sum_y;
        sxy_r   <= sum_xy;
        xty_got <= 1'b1;
      end
      if (accept) begin
        inv_got <= 1'b0;
        xty_got <= 1'b0;
      end
    end
  end

  // Shared multiplier operand select, one product per MUL step.
  always_comb begin
    mul_coef = a_r;
    mul_sum  = {1'b0, sy_r};
    case (k)
      2'd1: begin mul_coef = 32'(b_r); mul_sum = {1'b0, sxy_r}; end
      2'd2: begin mul_coef = 32'(b_r); mul_sum = {1'b0, sy_r};  end
      2'd3: begin mul_coef = 32'(c_r); mul_sum = {1'b0, sxy_r}; end
      default: ;
    endcase
  end

  assign prod     = PROD_W'(mul_coef) * PROD_W'(mul_sum);
  assign prod_ext = ACC_W'(prod);

  // Align the product to OUT_FRAC with an arithmetic shift (floor or round).
  always_comb begin
    aligned = '0;
    case (k)
      2'd0: aligned = (prod_ext + RND0) >>> SH0;
      2'd1: aligned = (prod_ext + RND1) >>> SH1;
      2'd2: aligned = (prod_ext + RND2) >>> SH2;
      2'd3: aligned = (prod_ext + RND3) >>> SH3;
      default: ;
    endcase
  end

  // Step counter and accumulators; steps 0-1 build beta0, 2-3 build beta1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= '0;
      acc0 <= '0;
      acc1 <= '0;
    end else begin
      if (mul_en) begin
        k <= k + 2'd1;
        if (!k[1]) acc0 <= acc0 + aligned;
        else       acc1 <= acc1 + aligned;
      end else begin
        k <= '0;
        if (accept) begin
          acc0 <= '0;
          acc1 <= '0;
        end
      end
    end
  end

  reg_coef_sat32 u_sat0 (.acc(acc0), .value(sat0_val), .ovf(ovf0));
  reg_coef_sat32 u_sat1 (.acc(acc1), .value(sat1_val), .ovf(ovf1));

  // Result registers: loaded in SAT, held through DONE until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beta0      <= '0;
      beta1      <= '0;
      sat        <= 1'b0;
      coef_valid <= 1'b0;
    end else if (load_en) begin
      beta0      <= sat0_val;
      beta1      <= sat1_val;
      sat        <= ovf0 | ovf1;
      coef_valid <= 1'b1;
    end else if (accept) begin
      coef_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_coef_solve.sv
// Directed self-checking bench for reg_coef_solve: coefficient values,
// saturation, truncation/rounding, latency, handshake and async reset.
module tb_reg_coef_solve;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               inv_valid;
  logic signed [31:0] inv_a;
  logic signed [19:0] inv_b;
  logic signed [20:0] inv_c;
  logic               xty_valid;
  logic [32:0]        sum_y;
  logic [32:0]        sum_xy;
  logic               coef_valid;
  logic               coef_ready;
  logic signed [31:0] beta0;
  logic signed [31:0] beta1;
  logic               sat;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int lat;
  int n_valid;
  logic [31:0] exp_round;

  always #5 clk = ~clk;

  reg_coef_solve dut (
    .clk(clk), .rst_n(rst_n),
    .inv_valid(inv_valid), .inv_a(inv_a), .inv_b(inv_b), .inv_c(inv_c),
    .xty_valid(xty_valid), .sum_y(sum_y), .sum_xy(sum_xy),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .beta0(beta0), .beta1(beta1), .sat(sat), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present both operands in the same cycle with a fresh inv_valid edge;
  // returns at the negedge right after the capture edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [19:0] b,
                               input logic [20:0] c, input logic [32:0] sy,
                               input logic [32:0] sxy);
    @(negedge clk);
    inv_valid  = 1'b0;
    coef_ready = 1'b0;
    @(negedge clk);
    inv_a     = a;
    inv_b     = b;
    inv_c     = c;
    sum_y     = sy;
    sum_xy    = sxy;
    inv_valid = 1'b1;
    xty_valid = 1'b1;
    @(negedge clk);
    xty_valid = 1'b0;
  endtask

  // Count clock edges from the capture edge until coef_valid, bounded.
  task automatic waitResult(output int latency);
    latency = 0;
    while (coef_valid !== 1'b1 && latency < 40) begin
      @(negedge clk);
      latency++;
    end
  endtask

  task automatic acceptResult(input string tag);
    coef_ready = 1'b1;
    @(negedge clk);
    coef_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'd0, coef_valid}, 32'd0);
    checkOutput({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
`ifdef REG_COEF_ROUND_EN
    exp_round = 32'd1;
`else
    exp_round = 32'd0;
`endif
    rst_n      = 1'b0;
    inv_valid  = 1'b0;
    inv_a      = '0;
    inv_b      = '0;
    inv_c      = '0;
    xty_valid  = 1'b0;
    sum_y      = '0;
    sum_xy     = '0;
    coef_ready = 1'b0;

    #1;
    checkOutput("rst_valid", {31'd0, coef_valid}, 32'd0);
    checkOutput("rst_beta0", beta0, 32'd0);
    checkOutput("rst_beta1", beta1, 32'd0);
    checkOutput("rst_sat",   {31'd0, sat}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // a=1.0, b=0, c=0.5, sum_y=10.0, sum_xy=4.0
    applyStimulus(32'd1024, 20'd0, 21'd32, 33'd2560, 33'd16384);
    waitResult(lat);
    checkOutput("t1_latency", 32'(lat), 32'd6);
    checkOutput("t1_beta0", beta0, 32'h000A0000);
    checkOutput("t1_beta1", beta1, 32'h00020000);
    checkOutput("t1_sat",   {31'd0, sat}, 32'd0);
    checkOutput("t1_busy",  {31'd0, busy}, 32'd1);

    // Downstream stalls for 10 cycles: result must hold.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", {31'd0, coef_valid}, 32'd1);
      checkOutput("stall_beta0", beta0, 32'h000A0000);
      checkOutput("stall_beta1", beta1, 32'h00020000);
    end
    acceptResult("t1");

    // b=-0.5: beta0=8.0, beta1=-3.0
    applyStimulus(32'd1024, 20'hFFF80, 21'd32, 33'd2560, 33'd16384);
    waitResult(lat);
    checkOutput("t2_latency", 32'(lat), 32'd6);
    checkOutput("t2_beta0", beta0, 32'h00080000);
    checkOutput("t2_beta1", beta1, 32'hFFFD0000);
    checkOutput("t2_sat",   {31'd0, sat}, 32'd0);
    acceptResult("t2");

    // Positive overflow.
    applyStimulus(32'h7FFFFFFF, 20'd0, 21'd0, 33'h1FFFFFFFF, 33'd0);
    waitResult(lat);
    checkOutput("t3_latency", 32'(lat), 32'd6);
    checkOutput("t3_beta0", beta0, 32'h7FFFFFFF);
    checkOutput("t3_beta1", beta1, 32'h00000000);
    checkOutput("t3_sat",   {31'd0, sat}, 32'd1);
    acceptResult("t3");

    // Negative overflow.
    applyStimulus(32'h80000000, 20'd0, 21'd0, 33'h1FFFFFFFF, 33'd0);
    waitResult(lat);
    checkOutput("t4_beta0", beta0, 32'h80000000);
    checkOutput("t4_sat",   {31'd0, sat}, 32'd1);
    acceptResult("t4");

    // 3/4 LSB: truncates to 0, rounds to 1.
    applyStimulus(32'd1, 20'd0, 21'd0, 33'd3, 33'd0);
    waitResult(lat);
    checkOutput("t5_beta0", beta0, exp_round);
    checkOutput("t5_beta1", beta1, 32'd0);
    checkOutput("t5_sat",   {31'd0, sat}, 32'd0);
    acceptResult("t5");

    // -3/4 LSB: floor and round-half-up both give -1.
    applyStimulus(32'hFFFFFFFF, 20'd0, 21'd0, 33'd3, 33'd0);
    waitResult(lat);
    checkOutput("t6_beta0", beta0, 32'hFFFFFFFF);
    acceptResult("t6");

    // xty pulse 5 cycles ahead of the inv_valid edge, inv then held high.
    @(negedge clk);
    inv_valid = 1'b0;
    sum_y     = 33'd2560;
    sum_xy    = 33'd16384;
    xty_valid = 1'b1;
    @(negedge clk);
    xty_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("early_busy", {31'd0, busy}, 32'd0);
    inv_a     = 32'd1024;
    inv_b     = 20'd0;
    inv_c     = 21'd32;
    inv_valid = 1'b1;
    @(negedge clk);
    waitResult(lat);
    checkOutput("early_latency", 32'(lat), 32'd6);
    checkOutput("early_beta0", beta0, 32'h000A0000);
    checkOutput("early_beta1", beta1, 32'h00020000);
    acceptResult("early");
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (coef_valid === 1'b1) n_valid++;
    end
    checkOutput("rearm_results", 32'(n_valid), 32'd0);
    checkOutput("rearm_busy", {31'd0, busy}, 32'd0);

    // Async reset during MUL step k=2.
    applyStimulus(32'd1024, 20'hFFF80, 21'd32, 33'd2560, 33'd16384);
    repeat (3) @(negedge clk);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, coef_valid}, 32'd0);
    checkOutput("mid_rst_beta0", beta0, 32'd0);
    checkOutput("mid_rst_beta1", beta1, 32'd0);
    checkOutput("mid_rst_sat",   {31'd0, sat}, 32'd0);
    checkOutput("mid_rst_busy",  {31'd0, busy}, 32'd0);
    #1 rst_n = 1'b1;

    // Full solve after the reset.
    applyStimulus(32'd1024, 20'hFFF80, 21'd32, 33'd2560, 33'd16384);
    waitResult(lat);
    checkOutput("post_latency", 32'(lat), 32'd6);
    checkOutput("post_beta0", beta0, 32'h00080000);
    checkOutput("post_beta1", beta1, 32'hFFFD0000);
    checkOutput("post_sat",   {31'd0, sat}, 32'd0);
    acceptResult("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
